st_ordered_demultiplexer: RTL

//  Splits one input stream across NB_OUT lanes. A lane is chosen round-robin among the

---
 rtl/st_ordered_demultiplexer.sv | 128 ++++++++++++
 1 files changed

// File: rtl/st_ordered_demultiplexer.sv
// rtl/st_ordered_demultiplexer.sv - round-robin stream splitter with arrival-order lane-id queue
module st_ordered_demultiplexer #(
  parameter int NB_OUT = 4,
  parameter int DWIDTH = 250,
  parameter int DEPTH  = 16,
  localparam int IW = (NB_OUT > 1) ? $clog2(NB_OUT) : 1,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = PW + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DWIDTH-1:0] in_data,
  output logic              out_valid [NB_OUT],
  input  logic              out_ready [NB_OUT],
  output logic [DWIDTH-1:0] out_data  [NB_OUT],
  output logic              order_valid,
  input  logic              order_ready,
  output logic [IW-1:0]     order_data
);

  if ((NB_OUT < 1) || ((NB_OUT & (NB_OUT - 1)) != 0)) begin : g_bad_nb_out
    $error("st_ordered_demultiplexer: NB_OUT must be a power of two");
  end
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("st_ordered_demultiplexer: DEPTH must be a power of two");
  end

  logic [NB_OUT-1:0] lane_valid_q;
  logic [DWIDTH-1:0] lane_data_q [NB_OUT];
  logic [NB_OUT-1:0] lane_free;
  logic [NB_OUT-1:0] lane_load;

  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IW-1:0] sel;
  logic [IW-1:0] idx;
  logic          any_free;
  logic          q_space;
  logic          accept;
  logic          pop;

  logic [IW-1:0] queue_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;

  // A lane is reusable in the same cycle its sink drains it.
  for (genvar i = 0; i < NB_OUT; i++) begin : g_lane
    assign lane_free[i] = !lane_valid_q[i] || out_ready[i];
    assign out_valid[i] = lane_valid_q[i];
    assign out_data[i]  = lane_data_q[i];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        lane_valid_q[i] <= 1'b0;
        lane_data_q[i]  <= '0;
      end else if (lane_load[i]) begin
        lane_valid_q[i] <= 1'b1;
        lane_data_q[i]  <= in_data;
      end else if (out_ready[i]) begin
        lane_valid_q[i] <= 1'b0;
      end
    end
  end

  always_comb begin
    sel      = '0;
    idx      = '0;
    any_free = 1'b0;
    for (int k = 0; k < NB_OUT; k++) begin
      idx = IW'((int'(rr_ptr_q) + k) % NB_OUT);
      if (!any_free && lane_free[idx]) begin
        sel      = idx;
        any_free = 1'b1;
      end
    end
  end

  // Space is judged on the registered count only, so in_ready never waits on order_ready.
  assign q_space     = (count_q < CW'(DEPTH));
  assign in_ready    = rst_n & any_free & q_space;
  assign accept      = in_valid & in_ready;
  assign order_valid = (count_q != '0);
  assign order_data  = queue_q[rd_ptr_q];
  assign pop         = order_valid & order_ready;

  always_comb begin
    lane_load = '0;
    if (accept) lane_load[sel] = 1'b1;
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (accept) rr_ptr_d = (sel == IW'(NB_OUT - 1)) ? '0 : sel + 1'b1;
  end

  always_comb begin
    count_d = count_q;
    if (accept && !pop)      count_d = count_q + 1'b1;
    else if (!accept && pop) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      count_q  <= count_d;
      if (accept) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)    rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) queue_q[wr_ptr_q] <= sel;
  end

  a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
    accept |-> (count_q < CW'(DEPTH)));
  a_no_pop_empty: assert property (@(posedge clk) disable iff (!rst_n)
    pop |-> (count_q != '0));
  a_load_onehot0: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(lane_load));

endmodule
